// File: rtl/cache_ctrl_2way_pkg.sv
// Shared types and geometry helpers for the 2-way set-associative cache controller.
package cache_ctrl_2way_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;

  function automatic int tag_bits(input int aw, input int ib, input int ob);
    return aw - ib - ob;
  endfunction

  function automatic int sram_aw(input int ib, input int ob);
    return 1 + ib + ob;
  endfunction

endpackage

// File: rtl/cache_ctrl_2way_if.sv
// CPU request/response and SDRAM strobe bus; slave is the cache side, master the environment.
interface cache_ctrl_2way_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] Address_cpu;
  logic                  wr_rd_cpu;
  logic                  cs_cpu;
  logic [DATA_WIDTH-1:0] DOut_cpu;
  logic [DATA_WIDTH-1:0] din_cpu;
  logic                  rdy_cpu;
  logic [ADDR_WIDTH-1:0] Address_sdram;
  logic [DATA_WIDTH-1:0] DOut_sdram;
  logic [DATA_WIDTH-1:0] din_sdram;
  logic                  wr_rd_sdram;
  logic                  mstrb_sdram;

  modport slave (
    input  Address_cpu, wr_rd_cpu, cs_cpu, DOut_cpu, DOut_sdram,
    output din_cpu, rdy_cpu, Address_sdram, din_sdram, wr_rd_sdram, mstrb_sdram
  );

  modport master (
    output Address_cpu, wr_rd_cpu, cs_cpu, DOut_cpu, DOut_sdram,
    input  din_cpu, rdy_cpu, Address_sdram, din_sdram, wr_rd_sdram, mstrb_sdram
  );
endinterface

// File: rtl/cache_ctrl_2way_data_sram.sv
// Cache data store: synchronous write, asynchronous read, addressed {way,index,offset}.
module cache_data_sram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative write-back/write-allocate cache controller with per-set LRU.
// Hit completes 2 cycles after the cs_cpu edge; misses stream whole blocks over the SDRAM strobe bus.
module cache_ctrl_2way
  import cache_ctrl_2way_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 5,
  parameter int SDRAM_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  cache_ctrl_2way_if.slave bus
);

  localparam int TAG_BITS = tag_bits(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS);
  localparam int SRAM_AW  = sram_aw(INDEX_BITS, OFFSET_BITS);
  localparam int NUM_SETS = 1 << INDEX_BITS;
  localparam int LAT_W    = (SDRAM_LAT > 0) ? $clog2(SDRAM_LAT + 1) : 1;
  localparam logic [LAT_W-1:0]       LAT_LAST  = LAT_W'(SDRAM_LAT);
  localparam logic [OFFSET_BITS-1:0] WORD_LAST = '1;

  state_t                  state, state_nxt;
  logic                    cs_prev;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_wr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    way;
  logic [OFFSET_BITS-1:0]  wcnt;
  logic [LAT_W-1:0]        lat_cnt;
  logic [DATA_WIDTH-1:0]   din_hold;

  logic [TAG_BITS-1:0]     tag_arr [2][NUM_SETS];
  logic [1:0]              valid [NUM_SETS];
  logic [1:0]              dirty [NUM_SETS];
  logic [NUM_SETS-1:0]     lru;

  logic [TAG_BITS-1:0]     req_tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [OFFSET_BITS-1:0]  req_off;
  logic                    hit0, hit1, hit, victim, start, word_done, last_word;

  logic                    sram_we;
  logic [SRAM_AW-1:0]      sram_waddr, sram_raddr;
  logic [DATA_WIDTH-1:0]   sram_wdata, sram_rdata;

  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_idx   = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_off   = req_addr[OFFSET_BITS-1:0];
  assign start     = (state == ST_IDLE) && bus.cs_cpu && !cs_prev;
  assign word_done = (lat_cnt == LAT_LAST);
  assign last_word = (wcnt == WORD_LAST);

  always_comb begin
    hit0 = valid[req_idx][0] && (tag_arr[0][req_idx] == req_tag);
    hit1 = valid[req_idx][1] && (tag_arr[1][req_idx] == req_tag);
    hit  = hit0 || hit1;
    if (!valid[req_idx][0])      victim = WAY0;
    else if (!valid[req_idx][1]) victim = WAY1;
    else                         victim = lru[req_idx];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)                          state_nxt = ST_DONE;
        else if (dirty[req_idx][victim])  state_nxt = ST_WB;
        else                              state_nxt = ST_FILL;
      end
      ST_WB:     if (word_done && last_word) state_nxt = ST_FILL;
      ST_FILL:   if (word_done && last_word) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Fill words land as they arrive; the CPU write lands last so it overrides the filled word.
  always_comb begin
    sram_we    = 1'b0;
    sram_waddr = {way, req_idx, wcnt};
    sram_wdata = bus.DOut_sdram;
    if (state == ST_FILL && word_done) begin
      sram_we = 1'b1;
    end else if (state == ST_DONE && req_wr) begin
      sram_we    = 1'b1;
      sram_waddr = {way, req_idx, req_off};
      sram_wdata = req_data;
    end
    sram_raddr = {way, req_idx, (state == ST_WB) ? wcnt : req_off};
  end

  cache_data_sram #(
    .AW (SRAM_AW),
    .DW (DATA_WIDTH)
  ) u_data_sram (
    .clk   (clk),
    .we    (sram_we),
    .waddr (sram_waddr),
    .wdata (sram_wdata),
    .raddr (sram_raddr),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cs_prev  <= 1'b0;
      req_addr <= '0;
      req_wr   <= 1'b0;
      req_data <= '0;
      way      <= WAY0;
      wcnt     <= '0;
      lat_cnt  <= '0;
      din_hold <= '0;
    end else begin
      state   <= state_nxt;
      cs_prev <= bus.cs_cpu;
      if (start) begin
        req_addr <= bus.Address_cpu;
        req_wr   <= bus.wr_rd_cpu;
        req_data <= bus.DOut_cpu;
      end
      case (state)
        ST_LOOKUP: begin
          way     <= hit1 ? WAY1 : (hit0 ? WAY0 : victim);
          wcnt    <= '0;
          lat_cnt <= '0;
        end
        ST_WB, ST_FILL: begin
          if (word_done) begin
            lat_cnt <= '0;
            wcnt    <= wcnt + 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_DONE: if (!req_wr) din_hold <= sram_rdata;
        default: ;
      endcase
    end
  end

  // The victim is invalidated as soon as a miss is decided so a half-filled way can never hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
      lru <= '0;
    end else begin
      case (state)
        ST_LOOKUP: begin
          if (hit) lru[req_idx] <= ~hit1;
          else     valid[req_idx][victim] <= 1'b0;
        end
        ST_WB: if (word_done && last_word) dirty[req_idx][way] <= 1'b0;
        ST_FILL: begin
          if (word_done && last_word) begin
            valid[req_idx][way] <= 1'b1;
            dirty[req_idx][way] <= 1'b0;
            lru[req_idx]        <= ~way;
          end
        end
        ST_DONE: if (req_wr) dirty[req_idx][way] <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_FILL && word_done && last_word) tag_arr[way][req_idx] <= req_tag;
  end

  assign bus.rdy_cpu       = (state == ST_DONE);
  assign bus.din_cpu       = (state == ST_DONE && !req_wr) ? sram_rdata : din_hold;
  assign bus.mstrb_sdram   = (state == ST_WB || state == ST_FILL) && (lat_cnt == '0);
  assign bus.wr_rd_sdram   = (state == ST_WB);
  assign bus.din_sdram     = (state == ST_WB) ? sram_rdata : '0;
  assign bus.Address_sdram = (state == ST_WB)   ? {tag_arr[way][req_idx], req_idx, wcnt} :
                             (state == ST_FILL) ? {req_tag, req_idx, wcnt} : '0;

endmodule
